// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single synchronous data memory.
// Define DMEM_ARB_RR_EN for round-robin ties; default is fixed priority to port 0.
module dmem_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              err0,
  output logic              err1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_dataIn,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_out
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    CAPTURE
  } state_t;

  state_t state;
  logic   port;
  logic   we_q;
  logic   mis_q;

  logic              pick;
  logic              sel_we;
  logic              sel_mis;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_RR_EN
  // Port favoured on a tie: the one not granted last.
  logic prio;

  always_comb begin
    pick = req1;
    if (req0 && req1)
      pick = prio;
  end
`else
  always_comb begin
    pick = !req0;
  end
`endif

  always_comb begin
    sel_we    = pick ? we1 : we0;
    sel_addr  = pick ? addr1 : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
    sel_mis   = |sel_addr[1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      port         <= 1'b0;
      we_q         <= 1'b0;
      mis_q        <= 1'b0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      mem_address  <= '0;
      mem_dataIn   <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
`ifdef DMEM_ARB_RR_EN
      prio         <= 1'b0;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 || req1) begin
            port  <= pick;
            we_q  <= sel_we;
            mis_q <= sel_mis;
            gnt0  <= !pick;
            gnt1  <= pick;
            // Misaligned accesses never touch the memory bus.
            if (!sel_mis) begin
              mem_address  <= sel_addr;
              mem_dataIn   <= sel_wdata;
              mem_write_en <= sel_we;
              mem_read_en  <= !sel_we;
            end
`ifdef DMEM_ARB_RR_EN
            prio  <= !pick;
`endif
            state <= ACCESS;
          end
        end
        ACCESS: begin
          mem_write_en <= 1'b0;
          if (we_q || mis_q) begin
            mem_read_en <= 1'b0;
            done0       <= !port;
            done1       <= port;
            err0        <= mis_q && !port;
            err1        <= mis_q && port;
            state       <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          mem_read_en <= 1'b0;
          if (port) rdata1 <= mem_out;
          else      rdata0 <= mem_out;
          done0 <= !port;
          done1 <= port;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed table, random transactions vs a
// transaction-level model, plus reset-abort and back-to-back sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_address, mem_dataIn, mem_out;
  logic        mem_write_en, mem_read_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_address(mem_address), .mem_dataIn(mem_dataIn),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_out(mem_out)
  );

  // Synchronous data memory stub.
  logic [31:0] ram [256];
  always @(posedge clk) begin
    if (mem_write_en) ram[mem_address[9:2]] <= mem_dataIn;
    if (mem_read_en) mem_out <= ram[mem_address[9:2]];
  end

  // Transaction-level reference state.
  logic [31:0] model_mem [256];
  logic [31:0] model_rd [2];
  logic        fav;

  typedef struct {
    logic        r0, r1, w0, w1;
    logic [31:0] a0, a1, d0, d1;
    logic        ep;
    int          lat;
    logic        eerr;
    logic [31:0] erd;
  } vec_t;

  function automatic void check(string nm, logic [63:0] got,
                                logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endfunction

  task automatic run_txn(input vec_t v, input string nm);
    int gc, gp, gn, dc, dp, dn, wc, rc;
    logic both, aok, ev, we, mis;
    logic [31:0] ea, ed;
    ea  = v.ep ? v.a1 : v.a0;
    ed  = v.ep ? v.d1 : v.d0;
    we  = v.ep ? v.w1 : v.w0;
    mis = |ea[1:0];
    gc = -1; gp = -1; gn = 0; dc = -1; dp = -1; dn = 0;
    wc = 0; rc = 0; both = 0; aok = 1; ev = 0;
    @(negedge clk);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
      if (gnt0 || gnt1) begin
        gn++; gc = c; gp = int'(gnt1);
        req0 = 0; req1 = 0;
      end
      if (done0 || done1) begin
        dn++; dc = c; dp = int'(done1);
        ev = done1 ? err1 : err0;
      end else if (err0 || err1) begin
        ev = 1'bx;
      end
      if (mem_write_en) begin
        wc++;
        if (mem_address != ea || mem_dataIn != ed) aok = 0;
      end
      if (mem_read_en) begin
        rc++;
        if (mem_address != ea) aok = 0;
      end
      if (mem_write_en && mem_read_en) both = 1;
    end
    check({nm, "_gnt"}, {32'(gn), 16'(gc), 16'(gp)},
          {32'd1, 16'd1, 16'(v.ep)});
    check({nm, "_done"}, {32'(dn), 16'(dc), 16'(dp)},
          {32'd1, 16'(v.lat), 16'(v.ep)});
    check({nm, "_err"}, 64'(ev), 64'(v.eerr));
    check({nm, "_rdata"}, 64'(v.ep ? rdata1 : rdata0), 64'(v.erd));
    check({nm, "_rdata_other"}, 64'(v.ep ? rdata0 : rdata1),
          64'(model_rd[!v.ep]));
    check({nm, "_bus"}, {16'(wc), 16'(rc), 16'(both), 16'(aok)},
          {16'((!mis && we) ? 1 : 0), 16'((!mis && !we) ? 2 : 0),
           16'd0, 16'd1});
    model_rd[v.ep] = v.erd;
    if (!mis && we) model_mem[ea[9:2]] = ed;
    fav = !v.ep;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    logic [31:0] ea;
    logic we;
    v.r0 = 1'($urandom); v.r1 = 1'($urandom);
    if (!v.r0 && !v.r1) v.r0 = 1;
    v.w0 = 1'($urandom); v.w1 = 1'($urandom);
    v.a0 = 1024 + 4 * $urandom_range(0, 15);
    v.a1 = 1024 + 4 * $urandom_range(0, 15);
    if ($urandom_range(0, 4) == 0) v.a0 += $urandom_range(1, 3);
    if ($urandom_range(0, 4) == 0) v.a1 += $urandom_range(1, 3);
    v.d0 = $urandom; v.d1 = $urandom;
`ifdef DMEM_ARB_RR_EN
    v.ep = (v.r0 && v.r1) ? fav : v.r1;
`else
    v.ep = !v.r0;
`endif
    ea = v.ep ? v.a1 : v.a0;
    we = v.ep ? v.w1 : v.w0;
    v.eerr = |ea[1:0];
    v.lat = (v.eerr || we) ? 2 : 3;
    v.erd = (!v.eerr && !we) ? model_mem[ea[9:2]] : model_rd[v.ep];
    return v;
  endfunction

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int q [$];
    logic [31:0] zr, tr;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 0;
      model_mem[i] = 0;
    end
    model_rd[0] = 0; model_rd[1] = 0; fav = 0;
    rst = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
    req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

    #3;
    check("reset_ctl",
          64'({gnt0, gnt1, done0, done1, err0, err1,
               mem_write_en, mem_read_en}), 64'd0);
    check("reset_data", {rdata0, rdata1}, 64'd0);
    check("reset_bus", {mem_address, mem_dataIn}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;

    //              r0 r1 w0 w1  a0    a1    d0   d1  ep lat err rdata
    tbl[0] = '{1, 0, 1, 0, 1124, 0,    100, 0,  0, 2, 0, 0};
    tbl[1] = '{1, 0, 0, 0, 1124, 0,    0,   0,  0, 3, 0, 100};
    tbl[2] = '{0, 1, 0, 0, 0,    1126, 0,   0,  1, 2, 1, 0};
    tbl[3] = '{0, 1, 0, 1, 0,    1128, 0,   55, 1, 2, 0, 0};
    tbl[4] = '{1, 1, 1, 0, 1200, 1128, 7,   0,  0, 2, 0, 100};
`ifdef DMEM_ARB_RR_EN
    tbl[5] = '{1, 1, 0, 0, 1128, 1200, 0,   0,  1, 3, 0, 7};
    tbl[6] = '{1, 0, 1, 0, 1127, 0,    9,   0,  0, 2, 1, 100};
`else
    tbl[5] = '{1, 1, 0, 0, 1128, 1200, 0,   0,  0, 3, 0, 55};
    tbl[6] = '{1, 0, 1, 0, 1127, 0,    9,   0,  0, 2, 1, 55};
`endif
    tbl[7] = '{1, 0, 0, 0, 1124, 0,    0,   0,  0, 3, 0, 100};
    tbl[8] = '{0, 1, 0, 0, 0,    1124, 0,   0,  1, 3, 0, 100};
    for (int i = 0; i < 9; i++)
      run_txn(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 150; i++)
      run_txn(rand_vec(), $sformatf("rnd%0d", i));

    // Reset asserted while a read sits in CAPTURE.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 1124;
    @(posedge clk);
    #1;
    check("abort_gnt", 64'({gnt0, gnt1}), 64'b10);
    req0 = 0;
    @(posedge clk);
    #1;
    check("abort_capture_rd", 64'(mem_read_en), 64'd1);
    #2;
    rst = 0;
    #1;
    check("abort_rd_drop", 64'({mem_read_en, mem_write_en}), 64'd0);
    check("abort_rdata", {rdata0, rdata1}, 64'd0);
    zr = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      zr |= 32'({done0, done1, mem_read_en, mem_write_en, gnt0, gnt1});
    end
    check("abort_quiet", 64'(zr), 64'd0);
    model_rd[0] = 0; model_rd[1] = 0; fav = 0;
    @(negedge clk);
    rst = 1;
    tbl[0] = '{1, 1, 1, 0, 1132, 1124, 9, 0, 0, 2, 0, 0};
    run_txn(tbl[0], "post_reset");

    // Both ports held high continuously.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 1300; wdata0 = 11;
    req1 = 1; we1 = 1; addr1 = 1304; wdata1 = 22;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      if (gnt0) q.push_back(0);
      if (gnt1) q.push_back(1);
    end
    req0 = 0; req1 = 0;
    repeat (4) @(posedge clk);
    #1;
    check("hold_count", 64'(q.size() >= 4), 64'd1);
    tr = 0; zr = 0;
    for (int k = 0; k < 4 && k < q.size(); k++) begin
      tr[k] = 1'(q[k]);
`ifdef DMEM_ARB_RR_EN
      zr[k] = fav ^ 1'(k & 1);
`else
      zr[k] = 1'b0;
`endif
    end
    check("hold_order", 64'(tr), 64'(zr));
    foreach (q[k]) begin
      if (q[k] == 0) model_mem[8'(1300 >> 2)] = 11;
      else           model_mem[8'(1304 >> 2)] = 22;
      fav = !1'(q[k]);
    end
    tbl[0] = '{1, 0, 0, 0, 1300, 0, 0, 0, 0, 3, 0, 11};
    run_txn(tbl[0], "hold_readback");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
